// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// frame geometry constants and the 2-of-3 vote used for bit decisions.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // 2-of-3 majority vote over three line samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte-delivery channel between the UART receiver and its consumer:
// valid/ready holding-register handshake plus the two error pulses.
interface uart_rx_8n1_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      data_valid;
    logic                      data_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs. Both flops
// reset to RESET_VAL so the output is well defined from reset onwards.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a cycle to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8-N-1 receiver. Synchronises rx, detects a start bit, samples each
// bit at mid-period (LSB first) and hands complete bytes to a one-entry
// valid/ready holding register. Framing errors and overruns are one-cycle
// pulses aligned with the edge where the byte would have been delivered.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over the samples at counts mid-2, mid-1 and mid; the decision
// edge and latency are unchanged.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_8n1_if.master bus
);

    localparam int               CNT_W         = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    logic                      w_rx_s;
    logic                      w_bit;
    logic                      w_accept;

    uart_rx_state_t            r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synchronised samples so the decision edge can vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = majority3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // The consumer can only take a byte that is actually held
    assign w_accept = r_valid & bus.data_ready;

    // Receive FSM, bit timing, shift register, holding register and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // A drain empties the register unless a new byte lands this edge
            if (w_accept) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= START;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                START: begin
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_bit) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_bit) begin
                            // Returning to IDLE at mid-stop lets the next start bit be seen
                            r_state <= IDLE;
                            if (!r_valid || w_accept) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                BREAK: begin
                    // A stuck-low line must go high before a new start is allowed
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= BREAK;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at 8 clocks per bit: a table of
// single frames plus hand-written sequences for back-to-back frames,
// overrun, drop-and-load, false start, reset mid-frame and (when built
// with UART_RX_MAJORITY_EN) a mid-sample glitch.
module tb_uart_rx_8n1;
    import uart_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [0:7];

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_e0  = 0;
    int rise_cyc = -1;
    int fall_cnt = 0;
    int ferr_cnt = 0;
    int ferr_cyc = -1;
    int ovr_cnt  = 0;
    int ovr_cyc  = -1;
    int t_dl     = 0;
    int t_rst    = 0;
    logic prev_valid = 1'b0;
    logic [7:0] rx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (rx_q.size() > i) return {24'h0, rx_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rise_cyc = -1;
        fall_cnt = 0;
        ferr_cnt = 0;
        ferr_cyc = -1;
        ovr_cnt  = 0;
        ovr_cyc  = -1;
    endtask

    // Call just after a negedge; returns just after a negedge at end of stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
        rx = 1'b0;
        last_e0 = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (glitch_bit == i) begin
                repeat (CPB / 2) @(negedge clk);
                rx = 1'b1;
                @(negedge clk);
                rx = d[i];
                repeat (CPB / 2 - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            repeat (2 * CPB) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Monitor: outputs sampled 1 after posedge, handshake 2 before next posedge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.data_valid && !prev_valid) rise_cyc = cyc;
            if (!bus.data_valid && prev_valid) fall_cnt++;
            prev_valid = bus.data_valid;
            if (bus.frame_err) begin
                ferr_cnt++;
                ferr_cyc = cyc;
            end
            if (bus.overrun) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            #7;
            if (bus.data_valid && bus.data_ready) rx_q.push_back(bus.data_out);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'hA5, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h5A, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h80, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h01, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};
        vecs[6] = '{data: 8'hA1, stop: 1'b0, exp_bytes: 0, exp_ferr: 1};
        vecs[7] = '{data: 8'h3C, stop: 1'b1, exp_bytes: 1, exp_ferr: 0};

        bus.data_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_valid", bus.data_valid, 1'b0);

        // Single byte, held until drained
        clear_mon();
        send_frame(8'hA1, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("single_latency", rise_cyc, last_e0 + 78);
        check("single_data", bus.data_out, 8'hA1);
        check("single_held", bus.data_valid, 1'b1);
        check("single_no_fall", fall_cnt, 0);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        @(negedge clk);
        check("single_drained", bus.data_valid, 1'b0);
        check("single_q", q_at(0), 8'hA1);

        // Table of single frames with the consumer always ready
        bus.data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            send_frame(vecs[i].data, vecs[i].stop, -1);
            repeat (2 * CPB) @(negedge clk);
            check($sformatf("vec%0d_bytes", i), rx_q.size(), vecs[i].exp_bytes);
            check($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_cnt, 0);
            if (vecs[i].exp_bytes > 0) begin
                check($sformatf("vec%0d_data", i), q_at(0), vecs[i].data);
                check($sformatf("vec%0d_latency", i), rise_cyc, last_e0 + 78);
            end else begin
                check($sformatf("vec%0d_no_valid", i), rise_cyc, -1);
                check($sformatf("vec%0d_ferr_cyc", i), ferr_cyc, last_e0 + 78);
            end
        end

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        repeat (2 * CPB) @(negedge clk);
        check("b2b_count", rx_q.size(), 2);
        check("b2b_first", q_at(0), 8'h55);
        check("b2b_second", q_at(1), 8'h0F);
        check("b2b_ferr", ferr_cnt, 0);

        // Overrun: second byte dropped, first kept
        bus.data_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_cycle", ovr_cyc, last_e0 + 78);
        check("ovr_data_kept", bus.data_out, 8'h11);
        check("ovr_valid", bus.data_valid, 1'b1);
        check("ovr_no_fall", fall_cnt, 0);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        @(negedge clk);
        check("ovr_drained", bus.data_valid, 1'b0);

        // Drop-and-load on the completion edge
        clear_mon();
        send_frame(8'h33, 1'b1, -1);
        fork
            send_frame(8'h22, 1'b1, -1);
            begin
                #1;
                t_dl = last_e0 + 77;
                for (int k = 0; k < 300 && cyc != t_dl; k++) @(negedge clk);
                check("dl_sync", cyc, t_dl);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("dl_data", bus.data_out, 8'h22);
        check("dl_valid", bus.data_valid, 1'b1);
        check("dl_no_fall", fall_cnt, 0);
        check("dl_no_ovr", ovr_cnt, 0);
        check("dl_took_old", q_at(0), 8'h33);
        bus.data_ready = 1'b1;
        @(negedge clk);

        // False start: 2-clock low glitch
        clear_mon();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("fs_no_valid", rise_cyc, -1);
        check("fs_no_ferr", ferr_cnt, 0);
        send_frame(8'h96, 1'b1, -1);
        repeat (2 * CPB) @(negedge clk);
        check("fs_next_count", rx_q.size(), 1);
        check("fs_next_data", q_at(0), 8'h96);

`ifdef UART_RX_MAJORITY_EN
        // One-clock high glitch at mid-sample of a zero data bit
        clear_mon();
        send_frame(8'hA0, 1'b1, 0);
        repeat (2 * CPB) @(negedge clk);
        check("maj_count", rx_q.size(), 1);
        check("maj_data", q_at(0), 8'hA0);
`endif

        // Reset during data bit 4 with a byte held
        bus.data_ready = 1'b0;
        clear_mon();
        send_frame(8'h5A, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("rmid_pre_valid", bus.data_valid, 1'b1);
        fork
            send_frame(8'hA1, 1'b1, -1);
            begin
                #1;
                t_rst = last_e0 + 44;
                for (int k = 0; k < 300 && cyc != t_rst; k++) @(negedge clk);
                check("rmid_sync", cyc, t_rst);
                #2;
                rst = 1'b1;
                #1;
                check("rmid_data_out", bus.data_out, 8'h00);
                check("rmid_valid", bus.data_valid, 1'b0);
                check("rmid_ferr", bus.frame_err, 1'b0);
                check("rmid_ovr", bus.overrun, 1'b0);
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (30) @(negedge clk);
        check("rmid_no_byte", rise_cyc, -1);
        check("rmid_no_ferr", ferr_cnt, 0);
        send_frame(8'hC3, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("rmid_next_latency", rise_cyc, last_e0 + 78);
        check("rmid_next_data", bus.data_out, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
